// File: rtl/button_pkg.sv
// ============================================================================
// Module : button_pkg
// Brief  : Shared types and helpers for the pushbutton input path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  // Raw pin level seen while the button is not pressed.
  function automatic logic released_level(input logic active_low);
    return active_low;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_reader_if.sv
// ============================================================================
// Module : button_reader_if
// Brief  : Raw pin input and conditioned level/event outputs of button_reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface button_reader_if;
  logic i_button;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_click;
  logic o_long;

  modport master (
    output i_button,
    input  o_level, o_press, o_release, o_click, o_long
  );

  modport slave (
    input  i_button,
    output o_level, o_press, o_release, o_click, o_long
  );
endinterface

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module : button_debounce
// Brief  : 2-flop synchronizer, polarity normalisation and counter debounce.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  wire logic i_clk,
  input  wire logic i_reset_n,
  input  wire logic i_button,
  output logic      o_level,
  output logic      o_change
);

  logic                     r_s1;
  logic                     r_s2;
  logic                     r_level;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic                     w_norm;
  logic                     w_differs;

  assign w_norm    = r_s2 ^ ACTIVE_LOW;
  assign w_differs = (w_norm != r_level);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1 <= released_level(ACTIVE_LOW);
      r_s2 <= released_level(ACTIVE_LOW);
    end else begin
      r_s1 <= i_button;
      r_s2 <= r_s1;
    end
  end

  // Any cycle that agrees with the current level restarts the window.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (!w_differs) begin
      r_cnt   <= '0;
    end else if (&r_cnt) begin
      r_level <= w_norm;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + DEBOUNCE_BITS'(1);
    end
  end

  // Strobe for the edge at which o_level flips, so event pulses can be
  // registered on that same edge.
  assign o_change = w_differs && (&r_cnt);
  assign o_level  = r_level;

endmodule

`default_nettype wire

// File: rtl/button_reader.sv
// ============================================================================
// Module : button_reader
// Brief  : Debounced pushbutton with press/release/click/long event pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter int LONG_BITS     = 24,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  wire logic       i_clk,
  input  wire logic       i_reset_n,
  button_reader_if.slave  btn
);

  logic                 w_level;
  logic                 w_change;
  btn_state_t           r_state;
  btn_state_t           w_state_next;
  logic [LONG_BITS-1:0] r_long_cnt;
  logic [LONG_BITS-1:0] w_long_cnt_next;
  logic [LONG_BITS-1:0] w_long_cnt_inc;
  logic                 r_press, r_release, r_click, r_long;
  logic                 w_press, w_release, w_click, w_long;

  button_debounce #(
    .DEBOUNCE_BITS (DEBOUNCE_BITS),
    .ACTIVE_LOW    (ACTIVE_LOW)
  ) u_debounce (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_button  (btn.i_button),
    .o_level   (w_level),
    .o_change  (w_change)
  );

  assign w_long_cnt_inc = r_long_cnt + LONG_BITS'(1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_long_cnt <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_click    <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_long_cnt <= w_long_cnt_next;
      r_press    <= w_press;
      r_release  <= w_release;
      r_click    <= w_click;
      r_long     <= w_long;
    end
  end

  // In IDLE the level is 0, so a change is a press; elsewhere it is a release.
  // A release on the threshold edge takes priority over the long event.
  always_comb begin
    w_state_next    = r_state;
    w_long_cnt_next = r_long_cnt;
    w_press         = 1'b0;
    w_release       = 1'b0;
    w_click         = 1'b0;
    w_long          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_change) begin
          w_state_next    = PRESSED;
          w_long_cnt_next = '0;
          w_press         = 1'b1;
        end
      end
      PRESSED: begin
        if (w_change) begin
          w_state_next = IDLE;
          w_release    = 1'b1;
          w_click      = 1'b1;
        end else begin
          w_long_cnt_next = w_long_cnt_inc;
          if (&w_long_cnt_inc) begin
            w_state_next = LONG;
            w_long       = 1'b1;
          end
        end
      end
      LONG: begin
        if (w_change) begin
          w_state_next = IDLE;
          w_release    = 1'b1;
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_long_cnt_next = '0;
      end
    endcase
  end

  assign btn.o_level   = w_level;
  assign btn.o_press   = r_press;
  assign btn.o_release = r_release;
  assign btn.o_click   = r_click;
  assign btn.o_long    = r_long;

endmodule

`default_nettype wire

// File: tb/tb_button_reader.sv
// ============================================================================
// Module : tb_button_reader
// Brief  : Scoreboard bench for button_reader (DEBOUNCE_BITS=4, LONG_BITS=6).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_reader;

  localparam int c_deb_lat  = 18;  // drive at negedge before E0 -> seen after E17
  localparam int c_long_lat = 63;

  localparam logic [3:0] c_ev_press   = 4'b1000;
  localparam logic [3:0] c_ev_release = 4'b0100;
  localparam logic [3:0] c_ev_click   = 4'b0010;
  localparam logic [3:0] c_ev_long    = 4'b0001;

  typedef struct {
    logic [3:0] mask;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  button_reader_if bif ();

  button_reader #(
    .DEBOUNCE_BITS (4),
    .LONG_BITS     (6),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .btn       (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] mask, input int at_cyc);
    exp_t e;
    e.mask = mask;
    e.cyc  = at_cyc;
    sb.push_back(e);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_level"},   int'(bif.o_level),   0);
    check({tag, "_press"},   int'(bif.o_press),   0);
    check({tag, "_release"}, int'(bif.o_release), 0);
    check({tag, "_click"},   int'(bif.o_click),   0);
    check({tag, "_long"},    int'(bif.o_long),    0);
  endtask

  logic [3:0] mon_mask;
  exp_t       mon_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_mask = {bif.o_press, bif.o_release, bif.o_click, bif.o_long};
      if (mon_mask != 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_evt", int'(mon_mask), 0);
        end else begin
          mon_exp = sb.pop_front();
          check("evt_mask", int'(mon_mask), int'(mon_exp.mask));
          check("evt_cyc", cyc, mon_exp.cyc);
        end
      end
    end
  end

  initial begin
    int c;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bif.i_button = 1'b1;

    // Reset, then idle with the pin released.
    tick(2);
    check_quiet("reset");
    rst_n = 1'b1;
    tick(100);
    check("idle_level", int'(bif.o_level), 0);

    // Press and hold; a held press eventually also produces the long event.
    c = cyc;
    bif.i_button = 1'b0;
    push(c_ev_press, c + c_deb_lat);
    push(c_ev_long,  c + c_deb_lat + c_long_lat);
    tick(c_deb_lat + 5);
    check("press_level", int'(bif.o_level), 1);

    // 5-cycle glitches toward released are shorter than the window.
    for (int i = 0; i < 12; i++) begin
      bif.i_button = ~bif.i_button;
      tick(5);
    end
    bif.i_button = 1'b0;
    tick(5);
    check("glitch_level", int'(bif.o_level), 1);

    c = cyc;
    bif.i_button = 1'b1;
    push(c_ev_release, c + c_deb_lat);
    tick(30);
    check("released_level", int'(bif.o_level), 0);

    // Short press: release 30 cycles after o_press -> click.
    c = cyc;
    bif.i_button = 1'b0;
    push(c_ev_press, c + c_deb_lat);
    tick(c_deb_lat + 30);
    bif.i_button = 1'b1;
    push(c_ev_release | c_ev_click, c + c_deb_lat + 30 + c_deb_lat);
    tick(30);

    // Long hold for 200 cycles.
    c = cyc;
    bif.i_button = 1'b0;
    push(c_ev_press, c + c_deb_lat);
    push(c_ev_long,  c + c_deb_lat + c_long_lat);
    tick(200);
    bif.i_button = 1'b1;
    push(c_ev_release, c + 200 + c_deb_lat);
    tick(30);

    // Release lands on the exact threshold edge: release and click, no long.
    c = cyc;
    bif.i_button = 1'b0;
    push(c_ev_press, c + c_deb_lat);
    tick(c_long_lat);
    bif.i_button = 1'b1;
    push(c_ev_release | c_ev_click, c + c_long_lat + c_deb_lat);
    tick(30);

    // Reset while in LONG with the pin held, then a fresh press.
    c = cyc;
    bif.i_button = 1'b0;
    push(c_ev_press, c + c_deb_lat);
    push(c_ev_long,  c + c_deb_lat + c_long_lat);
    tick(100);
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    tick(3);
    rst_n = 1'b1;
    c = cyc;
    push(c_ev_press, c + c_deb_lat);
    push(c_ev_long,  c + c_deb_lat + c_long_lat);
    tick(90);
    check("post_reset_level", int'(bif.o_level), 1);
    c = cyc;
    bif.i_button = 1'b1;
    push(c_ev_release, c + c_deb_lat);
    tick(30);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
